// File: rtl/lpc_host.sv
// LPC bus initiator: turns single-byte I/O or memory requests into LPC cycles,
// waits on peripheral SYNC with a bounded timeout and aborts hung cycles.
module lpc_host #(
    parameter int unsigned SYNC_TIMEOUT = 8,
    parameter int unsigned LONG_TIMEOUT = 64
) (
    input  logic        lpc_clock_i,
    input  logic        lpc_reset_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic        req_mem_i,
    input  logic [31:0] req_addr_i,
    input  logic [7:0]  req_wdata_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic [1:0]  rsp_status_o,
    output logic        lpc_frame_o,
    output logic [3:0]  lpc_ad_out_o,
    output logic        lpc_ad_oe_o,
    input  logic [3:0]  lpc_ad_in_i
);

    localparam int unsigned CntW = $clog2(LONG_TIMEOUT + 1);

    typedef enum logic [3:0] {
        StIdle, StStart, StCyct, StAddr, StWdata, StTar1, StTar2, StSync,
        StRdata, StTarb1, StTarb2, StAbort, StAbortIdle, StDone
    } state_e;

    state_e          state_q;
    logic            write_q;
    logic            mem_q;
    logic [31:0]     addr_q;
    logic [7:0]      wdata_q;
    logic [7:0]      rdata_q;
    logic [3:0]      nib_q;
    logic [CntW-1:0] wait_cnt_q;
    logic            long_q;
    logic [1:0]      status_q;

    logic            req_ready_q;
    logic            rsp_valid_q;
    logic [7:0]      rsp_data_q;
    logic [1:0]      rsp_status_q;
    logic            lpc_frame_q;
    logic [3:0]      lpc_ad_out_q;
    logic            lpc_ad_oe_q;

    logic            sync_wait;
    logic            long_now;
    logic [CntW-1:0] wait_limit;
    logic [CntW-1:0] cnt_inc;
    logic [3:0]      addr_nibs;

    always_comb begin
        sync_wait  = (lpc_ad_in_i != 4'b0000) && (lpc_ad_in_i != 4'b1010);
        long_now   = long_q || (lpc_ad_in_i == 4'b0110);
        wait_limit = long_now ? CntW'(LONG_TIMEOUT) : CntW'(SYNC_TIMEOUT);
        cnt_inc    = wait_cnt_q + 1'b1;
        addr_nibs  = mem_q ? 4'd8 : 4'd4;
    end

    // Outputs are set on the edge that enters a state, so they are valid for that whole cycle.
    always_ff @(posedge lpc_clock_i or negedge lpc_reset_ni) begin
        if (!lpc_reset_ni) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            mem_q        <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 8'h00;
            rdata_q      <= 8'h00;
            nib_q        <= 4'd0;
            wait_cnt_q   <= '0;
            long_q       <= 1'b0;
            status_q     <= 2'd0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 8'h00;
            rsp_status_q <= 2'd0;
            lpc_frame_q  <= 1'b1;
            lpc_ad_out_q <= 4'hF;
            lpc_ad_oe_q  <= 1'b0;
        end else begin
            lpc_frame_q  <= 1'b1;
            lpc_ad_oe_q  <= 1'b0;
            lpc_ad_out_q <= 4'hF;
            rsp_valid_q  <= 1'b0;
            req_ready_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (req_valid_i && req_ready_q) begin
                        write_q      <= req_write_i;
                        mem_q        <= req_mem_i;
                        // Left-justify I/O addresses so both widths shift out from bit 31.
                        addr_q       <= req_mem_i ? req_addr_i : {req_addr_i[15:0], 16'h0000};
                        wdata_q      <= req_wdata_i;
                        state_q      <= StStart;
                        lpc_frame_q  <= 1'b0;
                        lpc_ad_oe_q  <= 1'b1;
                        lpc_ad_out_q <= 4'h0;
                        req_ready_q  <= 1'b0;
                    end
                end
                StStart: begin
                    state_q      <= StCyct;
                    lpc_ad_oe_q  <= 1'b1;
                    lpc_ad_out_q <= {1'b0, mem_q, write_q, 1'b0};
                end
                StCyct: begin
                    state_q      <= StAddr;
                    lpc_ad_oe_q  <= 1'b1;
                    lpc_ad_out_q <= addr_q[31:28];
                    addr_q       <= {addr_q[27:0], 4'h0};
                    nib_q        <= 4'd1;
                end
                StAddr: begin
                    lpc_ad_oe_q <= 1'b1;
                    if (nib_q == addr_nibs) begin
                        if (write_q) begin
                            state_q      <= StWdata;
                            lpc_ad_out_q <= wdata_q[3:0];
                            nib_q        <= 4'd1;
                        end else begin
                            state_q <= StTar1;
                        end
                    end else begin
                        lpc_ad_out_q <= addr_q[31:28];
                        addr_q       <= {addr_q[27:0], 4'h0};
                        nib_q        <= nib_q + 4'd1;
                    end
                end
                StWdata: begin
                    lpc_ad_oe_q <= 1'b1;
                    if (nib_q == 4'd1) begin
                        lpc_ad_out_q <= wdata_q[7:4];
                        nib_q        <= 4'd2;
                    end else begin
                        state_q <= StTar1;
                    end
                end
                StTar1: state_q <= StTar2;
                StTar2: begin
                    state_q    <= StSync;
                    wait_cnt_q <= '0;
                    long_q     <= 1'b0;
                end
                StSync: begin
                    if (!sync_wait) begin
                        status_q <= (lpc_ad_in_i == 4'b1010) ? 2'd1 : 2'd0;
                        nib_q    <= 4'd0;
                        state_q  <= write_q ? StTarb1 : StRdata;
                    end else if (cnt_inc >= wait_limit) begin
                        state_q     <= StAbort;
                        lpc_frame_q <= 1'b0;
                        lpc_ad_oe_q <= 1'b1;
                        nib_q       <= 4'd0;
                    end else begin
                        wait_cnt_q <= cnt_inc;
                        long_q     <= long_now;
                    end
                end
                StRdata: begin
                    if (nib_q == 4'd0) begin
                        rdata_q[3:0] <= lpc_ad_in_i;
                        nib_q        <= 4'd1;
                    end else begin
                        rdata_q[7:4] <= lpc_ad_in_i;
                        state_q      <= StTarb1;
                    end
                end
                StTarb1: state_q <= StTarb2;
                StTarb2: begin
                    state_q      <= StDone;
                    rsp_valid_q  <= 1'b1;
                    rsp_data_q   <= write_q ? 8'h00 : rdata_q;
                    rsp_status_q <= status_q;
                end
                StAbort: begin
                    if (nib_q == 4'd3) begin
                        state_q <= StAbortIdle;
                    end else begin
                        lpc_frame_q <= 1'b0;
                        lpc_ad_oe_q <= 1'b1;
                        nib_q       <= nib_q + 4'd1;
                    end
                end
                StAbortIdle: begin
                    state_q      <= StDone;
                    rsp_valid_q  <= 1'b1;
                    rsp_data_q   <= 8'h00;
                    rsp_status_q <= 2'd2;
                end
                StDone: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_status_o = rsp_status_q;
    assign lpc_frame_o  = lpc_frame_q;
    assign lpc_ad_out_o = lpc_ad_out_q;
    assign lpc_ad_oe_o  = lpc_ad_oe_q;

endmodule

// File: tb/tb_lpc_host.sv
// Bench for lpc_host: a peripheral model answers SYNC/data on the bus while a
// scoreboard checks every response strobe against expectations queued at issue time.
module tb_lpc_host;

    localparam int SyncTo = 8;
    localparam int LongTo = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_mem = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [7:0]  req_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_status;
    logic        lpc_frame;
    logic [3:0]  lpc_ad_out;
    logic        lpc_ad_oe;
    logic [3:0]  lpc_ad_in = 4'hF;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];
    logic [3:0] sync_q[$];
    logic [9:0] mon_e;

    lpc_host #(.SYNC_TIMEOUT(SyncTo), .LONG_TIMEOUT(LongTo)) dut (
        .lpc_clock_i (clk),
        .lpc_reset_ni(rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_mem_i   (req_mem),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_status_o(rsp_status),
        .lpc_frame_o (lpc_frame),
        .lpc_ad_out_o(lpc_ad_out),
        .lpc_ad_oe_o (lpc_ad_oe),
        .lpc_ad_in_i (lpc_ad_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every response strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1, required no response (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_data", {24'h0, rsp_data}, {24'h0, mon_e[9:2]});
                chk("rsp_status", {30'h0, rsp_status}, {30'h0, mon_e[1:0]});
            end
        end
    end

    // Called at a negedge; returns at the negedge of the START cycle.
    task automatic issue(input bit wr, input bit mem, input logic [31:0] addr,
                         input logic [7:0] wd, output bit ok);
        req_write = wr;
        req_mem   = mem;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("req_accept", {31'h0, ok}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_txn(input bit wr, input bit mem, input logic [31:0] addr,
                           input logic [7:0] wd, input logic [7:0] rd);
        logic [3:0] drv[$];
        int na, nsync, cnt, i;
        bit lng, abort_exp, ok;
        logic [1:0] st;
        na = mem ? 8 : 4;
        drv.push_back(4'h0);
        drv.push_back({1'b0, mem, wr, 1'b0});
        for (int k = 0; k < na; k++) drv.push_back(addr[4*(na-1-k) +: 4]);
        if (wr) begin
            drv.push_back(wd[3:0]);
            drv.push_back(wd[7:4]);
        end
        drv.push_back(4'hF);
        nsync = 0; cnt = 0; lng = 0; abort_exp = 0; st = 2'd0;
        for (int k = 0; k < sync_q.size(); k++) begin
            nsync++;
            if (sync_q[k] == 4'h0) begin st = 2'd0; break; end
            if (sync_q[k] == 4'hA) begin st = 2'd1; break; end
            if (sync_q[k] == 4'h6) lng = 1;
            cnt++;
            if (cnt == (lng ? LongTo : SyncTo)) begin abort_exp = 1; break; end
        end
        exp_q.push_back(abort_exp ? {8'h00, 2'd2} : {(wr ? 8'h00 : rd), st});
        issue(wr, mem, addr, wd, ok);
        if (!ok) begin
            void'(exp_q.pop_back());
            return;
        end
        i = 0;
        for (int k = 0; k < drv.size(); k++) begin
            if (k > 0) begin
                @(negedge clk);
                i++;
            end
            chk("host_drive", {26'h0, lpc_frame, lpc_ad_oe, lpc_ad_out},
                {26'h0, (k != 0), 1'b1, drv[k]});
        end
        @(negedge clk); i++;
        chk("tar2_release", {30'h0, lpc_frame, lpc_ad_oe}, 32'h2);
        for (int s = 0; s < nsync; s++) begin
            @(negedge clk); i++;
            lpc_ad_in = sync_q[s];
            chk("sync_oe", {31'h0, lpc_ad_oe}, 32'h0);
        end
        if (abort_exp) begin
            for (int a = 0; a < 4; a++) begin
                @(negedge clk);
                lpc_ad_in = 4'hF;
                chk("abort_drive", {26'h0, lpc_frame, lpc_ad_oe, lpc_ad_out}, 32'h1F);
            end
            @(negedge clk);
            chk("abort_idle", {30'h0, lpc_frame, lpc_ad_oe}, 32'h2);
        end else begin
            if (!wr) begin
                @(negedge clk); i++;
                lpc_ad_in = rd[3:0];
                chk("rdata_oe", {31'h0, lpc_ad_oe}, 32'h0);
                @(negedge clk); i++;
                lpc_ad_in = rd[7:4];
                chk("rdata_oe", {31'h0, lpc_ad_oe}, 32'h0);
            end
            @(negedge clk); i++;
            lpc_ad_in = 4'hF;
            chk("tarb1_oe", {31'h0, lpc_ad_oe}, 32'h0);
            @(negedge clk); i++;
            chk("tarb2_oe", {31'h0, lpc_ad_oe}, 32'h0);
            chk("cycle_count", i, (mem ? 16 : 12) + nsync - 1);
        end
        @(negedge clk);
        chk("rsp_timing", {31'h0, rsp_valid}, 32'h1);
        @(negedge clk);
        chk("ready_return", {30'h0, req_ready, rsp_valid}, 32'h2);
    endtask

    task automatic fill_sync(input int n, input logic [3:0] wait_nib, input logic [3:0] term);
        sync_q.delete();
        for (int k = 0; k < n; k++) sync_q.push_back(wait_nib);
        sync_q.push_back(term);
    endtask

    initial begin
        bit ok, seen;
        logic [3:0] r;
        int nw;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", {22'h0, lpc_frame, lpc_ad_oe, lpc_ad_out, req_ready, rsp_valid,
                            rsp_status},
            {22'h0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0});
        chk("reset_rsp_data", {24'h0, rsp_data}, 32'h0);

        fill_sync(0, 4'h5, 4'h0);  run_txn(0, 0, 32'h0000_7FE5, 8'h00, 8'h6C);
        fill_sync(0, 4'h5, 4'h0);  run_txn(1, 0, 32'h0000_0080, 8'hA5, 8'h00);
        fill_sync(3, 4'h5, 4'h0);  run_txn(0, 1, 32'hFFFF_FFF0, 8'h00, 8'h13);
        fill_sync(8, 4'hF, 4'h0);  run_txn(0, 0, 32'h0000_1234, 8'h00, 8'h55);
        fill_sync(0, 4'h5, 4'hA);  run_txn(0, 0, 32'h0000_0060, 8'h00, 8'hEE);
        fill_sync(20, 4'h6, 4'h0); run_txn(0, 0, 32'h0000_0064, 8'h00, 8'h9A);
        fill_sync(7, 4'h5, 4'h0);  run_txn(1, 0, 32'h0000_03F8, 8'h3C, 8'h00);
        fill_sync(64, 4'h6, 4'h0); run_txn(1, 1, 32'h1234_5678, 8'h77, 8'h00);

        // Reset during the third address nibble.
        issue(0, 0, 32'h0000_ABCD, 8'h00, ok);
        repeat (4) @(negedge clk);
        chk("third_nibble", {28'h0, lpc_ad_out}, 32'hC);
        rst_n = 1'b0;
        #1;
        chk("reset_midcycle", {24'h0, lpc_frame, lpc_ad_oe, lpc_ad_out, req_ready, rsp_valid},
            {24'h0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("no_rsp_after_reset", {31'h0, seen}, 32'h0);
        fill_sync(1, 4'h5, 4'h0);  run_txn(0, 0, 32'h0000_ABCD, 8'h00, 8'h42);

        for (int n = 0; n < 40; n++) begin
            sync_q.delete();
            nw = $urandom_range(0, 10);
            for (int k = 0; k < nw; k++) begin
                r = 4'($urandom_range(0, 15));
                while (r == 4'h0 || r == 4'hA) r = 4'($urandom_range(0, 15));
                sync_q.push_back(r);
            end
            sync_q.push_back($urandom_range(0, 1) ? 4'hA : 4'h0);
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                    8'($urandom), 8'($urandom));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
